// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between the fetch/MEM stages, the arbiter and the
// single-ported unified memory.
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic [DATA_WIDTH-1:0] if_rdata;
    logic                  if_done;
    logic                  if_stall;
    logic                  d_req;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic [DATA_WIDTH-1:0] d_rdata;
    logic                  d_done;
    logic                  d_err;
    logic                  d_stall;
    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_rdata, if_done, if_stall, d_rdata, d_done, d_err, d_stall,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_rdata, if_done, if_stall, d_rdata, d_done, d_err, d_stall,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and MEM-stage accesses onto one synchronous memory port;
// data wins unless fetch has been deferred STARVE_LIMIT grants in a row.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1,
    parameter int STARVE_LIMIT = 4
) (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);
    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam bit GUARD_ON = (STARVE_LIMIT != 0);
    localparam logic [2:0] LAT = 3'(READ_LATENCY);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  we_q, we_d;
    logic [SW-1:0]         starve_q, starve_d;
    logic [2:0]            lat_q, lat_d;
    logic                  mem_en_q, mem_en_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic                  if_done_q, if_done_d;
    logic                  d_done_q, d_done_d;
    logic                  d_err_q, d_err_d;
    logic                  force_if;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        starve_d    = starve_q;
        lat_d       = lat_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_done_d   = 1'b0;
        d_done_d    = 1'b0;
        d_err_d     = 1'b0;
        force_if    = GUARD_ON && bus.if_req && (starve_q == STARVE_MAX);
        unique case (state_q)
            IDLE: begin
                if (bus.d_req && !force_if) begin
                    owner_d = 1'b1;
                    we_d    = bus.d_we;
                    if (!bus.if_req) begin
                        starve_d = '0;
                    end else if (starve_q != STARVE_MAX) begin
                        starve_d = starve_q + SW'(1);
                    end
                    // Misaligned data never reaches the memory
                    if (bus.d_addr[1:0] != 2'b00) begin
                        state_d  = RESP;
                        d_done_d = 1'b1;
                        d_err_d  = 1'b1;
                    end else begin
                        state_d     = ISSUE;
                        mem_en_d    = 1'b1;
                        mem_we_d    = bus.d_we;
                        mem_addr_d  = bus.d_addr;
                        mem_wdata_d = bus.d_wdata;
                    end
                end else if (bus.if_req) begin
                    owner_d    = 1'b0;
                    we_d       = 1'b0;
                    starve_d   = '0;
                    state_d    = ISSUE;
                    mem_en_d   = 1'b1;
                    mem_addr_d = bus.if_addr;
                end else begin
                    starve_d = '0;
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_d  = RESP;
                    d_done_d = 1'b1;
                end else begin
                    state_d = WAIT;
                    lat_d   = LAT;
                end
            end
            WAIT: begin
                if (lat_q == 3'd1) begin
                    state_d = RESP;
                    if (owner_q) begin
                        d_rdata_d = bus.mem_rdata;
                        d_done_d  = 1'b1;
                    end else begin
                        if_rdata_d = bus.mem_rdata;
                        if_done_d  = 1'b1;
                    end
                end else begin
                    lat_d = lat_q - 3'd1;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            starve_q    <= '0;
            lat_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_done_q   <= 1'b0;
            d_done_q    <= 1'b0;
            d_err_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            starve_q    <= starve_d;
            lat_q       <= lat_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_done_q   <= if_done_d;
            d_done_q    <= d_done_d;
            d_err_q     <= d_err_d;
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_done   = if_done_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_done    = d_done_q;
    assign bus.d_err     = d_err_q;
    assign bus.if_stall  = bus.if_req & ~if_done_q;
    assign bus.d_stall   = bus.d_req & ~d_done_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: dut_a (latency 1, starve limit 2) for arbitration,
// dut_b (latency 3) for reset during an outstanding read.
module tb_mem_port_arbiter;
    typedef struct {
        bit          is_d;
        bit          chk_data;
        logic [31:0] data;
        bit          err;
        int          rel;
    } resp_t;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          rel;
    } macc_t;

    logic clk = 1'b0;
    logic rst_a_n = 1'b0;
    logic rst_b_n = 1'b0;
    int   cyc = 0;
    int   base_a = 0;
    int   base_b = 0;
    int   total = 0;
    int   bad = 0;

    resp_t qa[$];
    resp_t qb[$];
    macc_t mq[$];

    logic [31:0] ram [64];
    logic [63:0] wflag = '0;
    logic [31:0] pb0, pb1, pb2;
    logic        prev_en_a = 1'b0;

    mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_a ();
    mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_b ();

    mem_port_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .READ_LATENCY(1), .STARVE_LIMIT(2)
    ) dut_a (
        .clk(clk), .reset(rst_a_n), .bus(bus_a)
    );

    mem_port_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .READ_LATENCY(3), .STARVE_LIMIT(4)
    ) dut_b (
        .clk(clk), .reset(rst_b_n), .bus(bus_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (wflag[a[7:2]]) return ram[a[7:2]];
        case (a)
            32'h0000_0040: return 32'h2108_000A;
            32'h0000_0044: return 32'h00A0_0093;
            32'h0000_0048: return 32'h00B0_0113;
            32'h1001_0008: return 32'hCAFE_F00D;
            32'h1001_000C: return 32'h0BAD_C0DE;
            default:       return 32'h0;
        endcase
    endfunction

    // Memory for dut_a: latency 1, garbage when no read was strobed
    always @(posedge clk) begin
        if (bus_a.mem_en && !bus_a.mem_we) bus_a.mem_rdata <= rd(bus_a.mem_addr);
        else bus_a.mem_rdata <= 32'h5A5A_5A5A;
        if (bus_a.mem_en && bus_a.mem_we) begin
            ram[bus_a.mem_addr[7:2]]   <= bus_a.mem_wdata;
            wflag[bus_a.mem_addr[7:2]] <= 1'b1;
        end
    end

    always @(posedge clk) begin
        pb0 <= (bus_b.mem_en && !bus_b.mem_we) ? rd(bus_b.mem_addr) : 32'h5A5A_5A5A;
        pb1 <= pb0;
        pb2 <= pb1;
    end
    assign bus_b.mem_rdata = pb2;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : mon_a
        resp_t r;
        macc_t m;
        if (rst_a_n) begin
            if (bus_a.if_done || bus_a.d_done) begin
                if (qa.size() == 0) begin
                    chk("a_unexpected_done", {30'b0, bus_a.d_done, bus_a.if_done}, 32'h0);
                end else begin
                    r = qa.pop_front();
                    chk("a_owner", 32'(bus_a.d_done), 32'(r.is_d));
                    chk("a_err", 32'(bus_a.d_err), 32'(r.err));
                    chk("a_cycle", 32'(cyc - base_a), 32'(r.rel));
                    if (r.chk_data)
                        chk("a_rdata", r.is_d ? bus_a.d_rdata : bus_a.if_rdata, r.data);
                end
            end
            if (bus_a.mem_en) begin
                chk("a_mem_gap", 32'(prev_en_a), 32'h0);
                if (mq.size() == 0) begin
                    chk("a_unexpected_mem", bus_a.mem_addr, 32'hFFFF_FFFF);
                end else begin
                    m = mq.pop_front();
                    chk("a_mem_we", 32'(bus_a.mem_we), 32'(m.we));
                    chk("a_mem_addr", bus_a.mem_addr, m.addr);
                    chk("a_mem_cycle", 32'(cyc - base_a), 32'(m.rel));
                    if (m.we) chk("a_mem_wdata", bus_a.mem_wdata, m.wdata);
                end
            end
        end
        prev_en_a <= bus_a.mem_en;
    end

    always @(negedge clk) begin : mon_b
        resp_t r;
        if (rst_b_n && (bus_b.if_done || bus_b.d_done)) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_done", {30'b0, bus_b.d_done, bus_b.if_done}, 32'h0);
            end else begin
                r = qb.pop_front();
                chk("b_rdata", bus_b.if_rdata, r.data);
                chk("b_cycle", 32'(cyc - base_b), 32'(r.rel));
            end
        end
    end

    task automatic run_a(input bit fi, input logic [31:0] fa, input bit fd,
                         input bit we, input logic [31:0] da, input logic [31:0] wd,
                         input int nif, input int nd, output int ist, output int dst);
        @(posedge clk);
        #1;
        base_a = cyc;
        bus_a.if_req  = fi;
        bus_a.if_addr = fa;
        bus_a.d_req   = fd;
        bus_a.d_we    = we;
        bus_a.d_addr  = da;
        bus_a.d_wdata = wd;
        ist = 0;
        dst = 0;
        for (int k = 0; k < 80 && (bus_a.if_req || bus_a.d_req); k++) begin
            #1;
            if (bus_a.if_stall) ist++;
            if (bus_a.d_stall) dst++;
            if (bus_a.if_done && nif > 0) begin
                nif--;
                if (nif == 0) bus_a.if_req = 1'b0;
            end
            if (bus_a.d_done && nd > 0) begin
                nd--;
                if (nd == 0) bus_a.d_req = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        chk("a_timeout", {30'b0, bus_a.d_req, bus_a.if_req}, 32'h0);
        bus_a.if_req = 1'b0;
        bus_a.d_req  = 1'b0;
    endtask

    task automatic run_b(input logic [31:0] fa, input int abort_at);
        @(posedge clk);
        #1;
        base_b = cyc;
        bus_b.if_req  = 1'b1;
        bus_b.if_addr = fa;
        for (int k = 0; k < 40 && bus_b.if_req; k++) begin
            #1;
            if (abort_at >= 0 && cyc - base_b == abort_at) begin
                rst_b_n = 1'b0;
                bus_b.if_req = 1'b0;
                #1;
                chk("b_rst_rdata", bus_b.if_rdata, 32'h0);
                chk("b_rst_addr", bus_b.mem_addr, 32'h0);
                chk("b_rst_ctl", {28'b0, bus_b.mem_en, bus_b.if_done,
                                  bus_b.if_stall, bus_b.d_done}, 32'h0);
            end else if (bus_b.if_done) begin
                bus_b.if_req = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        chk("b_timeout", 32'(bus_b.if_req), 32'h0);
        bus_b.if_req = 1'b0;
        rst_b_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ist, dst;
        bus_a.if_req = 1'b0; bus_a.if_addr = '0; bus_a.d_req = 1'b0;
        bus_a.d_we = 1'b0; bus_a.d_addr = '0; bus_a.d_wdata = '0;
        bus_b.if_req = 1'b0; bus_b.if_addr = '0; bus_b.d_req = 1'b0;
        bus_b.d_we = 1'b0; bus_b.d_addr = '0; bus_b.d_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("a_reset_ctl", {26'b0, bus_a.if_done, bus_a.d_done, bus_a.d_err,
                            bus_a.mem_en, bus_a.mem_we, bus_a.if_stall}, 32'h0);
        chk("a_reset_addr", bus_a.mem_addr, 32'h0);
        chk("a_reset_wdata", bus_a.mem_wdata, 32'h0);
        chk("a_reset_rdata", bus_a.if_rdata | bus_a.d_rdata, 32'h0);
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;

        // Single fetch
        qa.push_back('{1'b0, 1'b1, 32'h2108_000A, 1'b0, 3});
        mq.push_back('{1'b0, 32'h0000_0040, 32'h0, 1});
        run_a(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 1, 0, ist, dst);
        chk("a_fetch_if_stall", 32'(ist), 32'd3);

        // Aligned write, then read it back
        qa.push_back('{1'b1, 1'b0, 32'h0, 1'b0, 2});
        mq.push_back('{1'b1, 32'h1001_0004, 32'hDEAD_BEEF, 1});
        run_a(1'b0, 32'h0, 1'b1, 1'b1, 32'h1001_0004, 32'hDEAD_BEEF, 0, 1, ist, dst);
        chk("a_write_d_stall", 32'(dst), 32'd2);
        qa.push_back('{1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 3});
        mq.push_back('{1'b0, 32'h1001_0004, 32'h0, 1});
        run_a(1'b0, 32'h0, 1'b1, 1'b0, 32'h1001_0004, 32'h0, 0, 1, ist, dst);

        // Simultaneous: data first, fetch at next idle
        qa.push_back('{1'b1, 1'b1, 32'hCAFE_F00D, 1'b0, 3});
        qa.push_back('{1'b0, 1'b1, 32'h00A0_0093, 1'b0, 7});
        mq.push_back('{1'b0, 32'h1001_0008, 32'h0, 1});
        mq.push_back('{1'b0, 32'h0000_0044, 32'h0, 5});
        run_a(1'b1, 32'h44, 1'b1, 1'b0, 32'h1001_0008, 32'h0, 1, 1, ist, dst);
        chk("a_both_if_stall", 32'(ist), 32'd7);

        // Continuous data traffic: D, D, IF, D
        qa.push_back('{1'b1, 1'b1, 32'h0BAD_C0DE, 1'b0, 3});
        qa.push_back('{1'b1, 1'b1, 32'h0BAD_C0DE, 1'b0, 7});
        qa.push_back('{1'b0, 1'b1, 32'h00B0_0113, 1'b0, 11});
        qa.push_back('{1'b1, 1'b1, 32'h0BAD_C0DE, 1'b0, 15});
        mq.push_back('{1'b0, 32'h1001_000C, 32'h0, 1});
        mq.push_back('{1'b0, 32'h1001_000C, 32'h0, 5});
        mq.push_back('{1'b0, 32'h0000_0048, 32'h0, 9});
        mq.push_back('{1'b0, 32'h1001_000C, 32'h0, 13});
        run_a(1'b1, 32'h48, 1'b1, 1'b0, 32'h1001_000C, 32'h0, 1, 3, ist, dst);
        chk("a_starve_if_stall", 32'(ist), 32'd11);

        // Misaligned load: error in one cycle, memory untouched
        qa.push_back('{1'b1, 1'b0, 32'h0, 1'b1, 1});
        run_a(1'b0, 32'h0, 1'b1, 1'b0, 32'h1001_0002, 32'h0, 0, 1, ist, dst);
        chk("a_misalign_d_stall", 32'(dst), 32'd1);

        // dut_b: full fetch, fetch aborted by reset in WAIT, fresh fetch
        qb.push_back('{1'b0, 1'b1, 32'h2108_000A, 1'b0, 5});
        run_b(32'h40, -1);
        run_b(32'h48, 3);
        qb.push_back('{1'b0, 1'b1, 32'h00B0_0113, 1'b0, 5});
        run_b(32'h48, -1);

        repeat (6) @(posedge clk);
        #1;
        chk("a_resp_left", 32'(qa.size()), 32'h0);
        chk("a_mem_left", 32'(mq.size()), 32'h0);
        chk("b_resp_left", 32'(qb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
